// File: rtl/branch_resolve_pipe.sv
// IF/ID and ID/EX pipeline registers feeding the BTB update port: resolves
// branch/JAL/JALR direction and target in EX and keeps retirement statistics.
module branch_resolve_pipe #(
    parameter int CNT_W   = 16,
    parameter bit CNT_SAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memory_stall,
    input  logic             flush_in,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic             id_is_jalr,
    input  logic [2:0]       id_funct3,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    output logic [31:0]      instructionPC_3,
    output logic             is_branchInst_3,
    output logic             taken_3,
    output logic             prev_taken_3,
    output logic [31:0]      target_3,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic        ifid_pred;

    logic        idex_valid;
    logic [31:0] idex_pc;
    logic        idex_pred;
    logic        idex_is_branch;
    logic        idex_is_jal;
    logic        idex_is_jalr;
    logic [2:0]  idex_funct3;
    logic [31:0] idex_imm;

    // Stall outranks flush, so a flush arriving during a stall is applied on
    // the first un-stalled edge (the redirect source in EX is held too).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid     <= 1'b0;
            ifid_pc        <= '0;
            ifid_pred      <= 1'b0;
            idex_valid     <= 1'b0;
            idex_pc        <= '0;
            idex_pred      <= 1'b0;
            idex_is_branch <= 1'b0;
            idex_is_jal    <= 1'b0;
            idex_is_jalr   <= 1'b0;
            idex_funct3    <= '0;
            idex_imm       <= '0;
        end else if (!memory_stall) begin
            if (flush_in) begin
                ifid_valid <= 1'b0;
                idex_valid <= 1'b0;
            end else begin
                ifid_valid     <= if_valid;
                ifid_pc        <= if_pc;
                ifid_pred      <= if_pred_taken;
                idex_valid     <= ifid_valid;
                idex_pc        <= ifid_pc;
                idex_pred      <= ifid_pred;
                idex_is_branch <= id_is_branch;
                idex_is_jal    <= id_is_jal;
                idex_is_jalr   <= id_is_jalr;
                idex_funct3    <= id_funct3;
                idex_imm       <= id_imm;
            end
        end
    end

    logic        cond_true;
    logic        is_ctrl;
    logic        resolved_taken;
    logic [31:0] pc_plus_imm;
    logic [31:0] pc_plus_4;
    logic [31:0] jalr_target;

    always_comb begin
        cond_true = 1'b0;
        case (idex_funct3)
            3'b000:  cond_true = (ex_rs1 == ex_rs2);
            3'b001:  cond_true = (ex_rs1 != ex_rs2);
            3'b100:  cond_true = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond_true = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond_true = (ex_rs1 <  ex_rs2);
            3'b111:  cond_true = (ex_rs1 >= ex_rs2);
            default: cond_true = 1'b0;
        endcase
    end

    assign is_ctrl        = idex_is_branch | idex_is_jal | idex_is_jalr;
    assign resolved_taken = idex_is_jal | idex_is_jalr | (idex_is_branch & cond_true);
    assign pc_plus_imm    = idex_pc + idex_imm;
    assign pc_plus_4      = idex_pc + 32'd4;
    assign jalr_target    = (ex_rs1 + idex_imm) & 32'hFFFF_FFFE;

    // Bubbles drive a zero target so the port reads all-zero after reset.
    always_comb begin
        target_3 = '0;
        if (idex_valid) begin
            if (idex_is_jalr)
                target_3 = jalr_target;
            else if (resolved_taken)
                target_3 = pc_plus_imm;
            else
                target_3 = pc_plus_4;
        end
    end

    assign instructionPC_3 = idex_pc;
    assign is_branchInst_3 = idex_valid & is_ctrl;
    assign taken_3         = idex_valid & resolved_taken;
    assign prev_taken_3    = idex_valid & idex_pred;

    logic count_en;
    logic mispredict;

    assign count_en   = !memory_stall && is_branchInst_3;
    assign mispredict = taken_3 != prev_taken_3;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur);
        if (CNT_SAT && (cur == {CNT_W{1'b1}}))
            return cur;
        return cur + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (count_en) begin
            branch_count <= cnt_next(branch_count);
            if (mispredict)
                mispredict_count <= cnt_next(mispredict_count);
        end
    end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Scoreboard bench for branch_resolve_pipe: directed branch vectors with
// hand-computed results, flush/stall cases, counter saturation and async reset.
module tb_branch_resolve_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memory_stall = 1'b0;
    logic        flush_in = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred_taken = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_is_jal = 1'b0;
    logic        id_is_jalr = 1'b0;
    logic [2:0]  id_funct3 = '0;
    logic [31:0] id_imm = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;

    logic [31:0] instructionPC_3, target_3;
    logic        is_branchInst_3, taken_3, prev_taken_3;
    logic [15:0] branch_count, mispredict_count;

    logic [31:0] s_pc, s_target;
    logic        s_isbr, s_taken, s_prev;
    logic [1:0]  s_bc, s_mc;

    branch_resolve_pipe dut (
        .clk(clk), .rst(rst), .memory_stall(memory_stall), .flush_in(flush_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
        .id_funct3(id_funct3), .id_imm(id_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .instructionPC_3(instructionPC_3), .is_branchInst_3(is_branchInst_3),
        .taken_3(taken_3), .prev_taken_3(prev_taken_3), .target_3(target_3),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_resolve_pipe #(.CNT_W(2), .CNT_SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .memory_stall(memory_stall), .flush_in(flush_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
        .id_funct3(id_funct3), .id_imm(id_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .instructionPC_3(s_pc), .is_branchInst_3(s_isbr),
        .taken_3(s_taken), .prev_taken_3(s_prev), .target_3(s_target),
        .branch_count(s_bc), .mispredict_count(s_mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
        logic [31:0] target;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_br = '0;
    logic [15:0] exp_mp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: retires one scoreboard entry per un-stalled EX control transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_br = '0;
            exp_mp = '0;
        end else if (is_branchInst_3 && !memory_stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: branch at pc 0x%08h with empty scoreboard", instructionPC_3);
            end else begin
                e = exp_q.pop_front();
                chk("mon_pc", instructionPC_3, e.pc);
                chk("mon_taken", 32'(taken_3), 32'(e.taken));
                chk("mon_prev_taken", 32'(prev_taken_3), 32'(e.pred));
                chk("mon_target", target_3, e.target);
                chk("mon_branch_count", 32'(branch_count), 32'(exp_br));
                chk("mon_mispredict_count", 32'(mispredict_count), 32'(exp_mp));
                exp_br = exp_br + 16'd1;
                if (e.taken != e.pred)
                    exp_mp = exp_mp + 16'd1;
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic pred,
                            input logic taken, input logic [31:0] target);
        exp_t e;
        e.pc = pc; e.pred = pred; e.taken = taken; e.target = target;
        exp_q.push_back(e);
    endtask

    task automatic set_decode(input logic [2:0] kind, input logic [2:0] f3, input logic [31:0] imm);
        id_is_branch = kind[0];
        id_is_jal    = kind[1];
        id_is_jalr   = kind[2];
        id_funct3    = f3;
        id_imm       = imm;
    endtask

    // kind: bit0 branch, bit1 JAL, bit2 JALR
    task automatic issue(input logic [31:0] pc, input logic pred, input logic [2:0] kind,
                         input logic [2:0] f3, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic exp_taken, input logic [31:0] exp_target);
        push_exp(pc, pred, exp_taken, exp_target);
        if_valid = 1'b1; if_pc = pc; if_pred_taken = pred;
        tick();
        if_valid = 1'b0;
        set_decode(kind, f3, imm);
        tick();
        set_decode(3'b000, 3'b000, 32'h0);
        ex_rs1 = rs1; ex_rs2 = rs2;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc"}, instructionPC_3, 32'h0);
        chk({tag, "_isbr"}, 32'(is_branchInst_3), 32'h0);
        chk({tag, "_taken"}, 32'(taken_3), 32'h0);
        chk({tag, "_prev"}, 32'(prev_taken_3), 32'h0);
        chk({tag, "_target"}, target_3, 32'h0);
        chk({tag, "_bc"}, 32'(branch_count), 32'h0);
        chk({tag, "_mc"}, 32'(mispredict_count), 32'h0);
        chk({tag, "_sat_bc"}, 32'(s_bc), 32'h0);
        chk({tag, "_sat_mc"}, 32'(s_mc), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        issue(32'h100, 1'b0, 3'b001, 3'b000, 32'h40, 32'd5, 32'd5, 1'b1, 32'h140);
        chk("beq_branch_count", 32'(branch_count), 32'd1);
        chk("beq_mispredict_count", 32'(mispredict_count), 32'd1);
        issue(32'h200, 1'b1, 3'b001, 3'b100, 32'h80, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h280);
        issue(32'h300, 1'b1, 3'b001, 3'b110, 32'h80, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h304);
        issue(32'h400, 1'b1, 3'b100, 3'b000, 32'h10, 32'h2003, 32'd0, 1'b1, 32'h2012);
        issue(32'h500, 1'b0, 3'b010, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b1, 32'h4F0);
        issue(32'h600, 1'b0, 3'b001, 3'b001, 32'h20, 32'd3, 32'd3, 1'b0, 32'h604);
        issue(32'h700, 1'b0, 3'b001, 3'b101, 32'h100, 32'h8000_0000, 32'd0, 1'b0, 32'h704);
        issue(32'h700, 1'b1, 3'b001, 3'b111, 32'h100, 32'h8000_0000, 32'd0, 1'b1, 32'h800);
        issue(32'h900, 1'b0, 3'b001, 3'b010, 32'h8, 32'd9, 32'd9, 1'b0, 32'h904);
        chk("vec_branch_count", 32'(branch_count), 32'd9);
        chk("vec_mispredict_count", 32'(mispredict_count), 32'd3);

        // Flush with valid instructions in both IF/ID and ID/EX.
        push_exp(32'hB00, 1'b1, 1'b1, 32'hB10);
        if_valid = 1'b1; if_pc = 32'hB00; if_pred_taken = 1'b1;
        tick();
        set_decode(3'b001, 3'b000, 32'h10);
        if_pc = 32'hC00; if_pred_taken = 1'b0;
        tick();
        set_decode(3'b001, 3'b000, 32'h10);
        if_pc = 32'hD00;
        ex_rs1 = 32'd7; ex_rs2 = 32'd7;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_bubble1", 32'(is_branchInst_3), 32'h0);
        tick();
        @(negedge clk);
        chk("flush_bubble2", 32'(is_branchInst_3), 32'h0);
        tick();
        set_decode(3'b000, 3'b000, 32'h0);
        chk("flush_branch_count", 32'(branch_count), 32'd10);
        chk("flush_mispredict_count", 32'(mispredict_count), 32'd3);

        // BNE held in EX across a 3-cycle stall.
        push_exp(32'hE00, 1'b1, 1'b1, 32'hE40);
        if_valid = 1'b1; if_pc = 32'hE00; if_pred_taken = 1'b1;
        tick();
        if_valid = 1'b0;
        set_decode(3'b001, 3'b001, 32'h40);
        tick();
        set_decode(3'b000, 3'b000, 32'h0);
        ex_rs1 = 32'd1; ex_rs2 = 32'd2;
        memory_stall = 1'b1;
        if_valid = 1'b1; if_pc = 32'hF00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", instructionPC_3, 32'hE00);
            chk("stall_isbr", 32'(is_branchInst_3), 32'h1);
            chk("stall_target", target_3, 32'hE40);
            chk("stall_branch_count", 32'(branch_count), 32'd10);
            tick();
        end
        memory_stall = 1'b0;
        if_valid = 1'b0;
        tick();
        chk("stall_branch_count_after", 32'(branch_count), 32'd11);
        tick();
        chk("stall_branch_count_final", 32'(branch_count), 32'd11);

        // Saturation on the CNT_W=2 instance.
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset2");
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++)
            issue(32'h1000 + 32'(i * 16), 1'b0, 3'b001, 3'b000, 32'h20, 32'd4, 32'd4, 1'b1,
                  32'h1020 + 32'(i * 16));
        chk("sat_bc", 32'(s_bc), 32'd3);
        chk("sat_mc", 32'(s_mc), 32'd3);
        chk("wide_bc", 32'(branch_count), 32'd5);
        chk("wide_mc", 32'(mispredict_count), 32'd5);

        // Async reset with a live branch in EX, between clock edges.
        if_valid = 1'b1; if_pc = 32'h3000; if_pred_taken = 1'b1;
        tick();
        if_valid = 1'b0;
        set_decode(3'b010, 3'b000, 32'h8);
        @(posedge clk); #1;
        chk("pre_async_isbr", 32'(is_branchInst_3), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        set_decode(3'b000, 3'b000, 32'h0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_pipe.md
Name: branch_resolve_pipe

Overview:
- Producer side of the BTB stage-3 update/redirect interface.
- Carries each fetched PC and its BTB direction prediction through the IF/ID and ID/EX pipeline registers.
- Resolves branch/jump outcome and target in EX, and drives instructionPC_3, is_branchInst_3, taken_3, prev_taken_3 and target_3 to the BTB.
- Also keeps resolved-branch and misprediction statistics counters.

Parameters:
CNT_W, 16, width of the statistics counters
CNT_SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
memory_stall  input  1  global stall; all pipeline registers hold
flush_in  input  1  BTB flush (misprediction redirect in progress)
if_valid  input  1  IF stage holds a real instruction
if_pc  input  32  IF-stage PC (the BTB's instructionPC_1)
if_pred_taken  input  1  BTB taken prediction for if_pc
id_is_branch  input  1  ID instruction is a conditional branch
id_is_jal  input  1  ID instruction is JAL
id_is_jalr  input  1  ID instruction is JALR
id_funct3  input  3  ID branch funct3
id_imm  input  32  ID sign-extended immediate
ex_rs1  input  32  forwarded rs1 value for the EX instruction
ex_rs2  input  32  forwarded rs2 value for the EX instruction
instructionPC_3  output  32  EX-stage PC
is_branchInst_3  output  1  EX holds a valid branch/JAL/JALR
taken_3  output  1  resolved direction
prev_taken_3  output  1  direction predicted at fetch
target_3  output  32  resolved next PC
branch_count  output  CNT_W  resolved control-transfer count
mispredict_count  output  CNT_W  direction-misprediction count

Behaviour:
- Pipeline registers:
  - IF/ID holds {valid, pc, pred}.
  - ID/EX holds {valid, pc, pred, is_branch, is_jal, is_jalr, funct3, imm}.
- Reset (async, rst=1): every register and both counters go to 0 immediately. All outputs read 0 while rst is high and until the first fill.
- Each rising edge, in priority order:
  - memory_stall=1: hold everything, counters included. This priority holds even if flush_in=1; flush_in stays asserted because EX is held.
  - else flush_in=1: IF/ID.valid <= 0 and ID/EX.valid <= 0 (both become bubbles); the other fields are don't-care. The EX instruction itself retires normally.
  - else: IF/ID <= {if_valid, if_pc, if_pred_taken}. ID/EX <= IF/ID contents plus the id_* decode fields.
- Latency: a PC presented in IF appears on instructionPC_3 two un-stalled, un-flushed edges later.
- EX outputs (combinational from ID/EX and ex_rs1/ex_rs2):
  - instructionPC_3 = ID/EX.pc.
  - prev_taken_3 = ID/EX.pred & ID/EX.valid.
  - is_branchInst_3 = ID/EX.valid & (is_branch | is_jal | is_jalr).
- taken_3:
  - JAL or JALR: 1.
  - Branch, by funct3: 000 BEQ (==); 001 BNE (!=); 100 BLT (signed <); 101 BGE (signed >=); 110 BLTU (unsigned <); 111 BGEU (unsigned >=); 010/011 resolve as not taken.
  - Not a control transfer or not valid: 0.
- target_3, all sums mod 2^32:
  - taken branch or JAL: pc + imm.
  - JALR: (rs1 + imm) & ~1.
  - not-taken branch: pc + 4.
  - otherwise: pc + 4.
- Counters update only on an edge with memory_stall=0 and is_branchInst_3=1:
  - branch_count += 1.
  - mispredict_count += 1 if taken_3 != prev_taken_3.
  - At all-ones: hold when CNT_SAT=1, wrap to 0 when CNT_SAT=0.
- Stall cases:
  - A stall during the flush cycle delays the bubble insertion until the first un-stalled edge.
  - A stall never double-counts a branch.
- Reset asserted mid-stall or mid-flush clears all state in the same cycle; no pending flush survives reset.

Test Plan:
- BEQ at pc=0x100, imm=0x40, rs1=rs2=5, pred=0, two clean edges -> instructionPC_3=0x100, is_branchInst_3=1, taken_3=1, prev_taken_3=0, target_3=0x140; after next edge mispredict_count=1, branch_count=1.
- BLT with rs1=0xFFFFFFFF, rs2=1, and BLTU with the same operands -> BLT taken_3=1, BLTU taken_3=0 with target_3=pc+4.
- JALR with rs1=0x2003, imm=0x10, pred=1 -> taken_3=1, target_3=0x2012; no mispredict count.
- flush_in=1 for one un-stalled edge with valid IF/ID and ID/EX -> next cycle is_branchInst_3=0, and again the cycle after (both bubbles); counters unchanged by the bubbles.
- memory_stall=1 for 3 cycles with a BNE held in EX -> outputs constant and branch_count increments exactly once, after the stall drops.
- CNT_W=2, CNT_SAT=1 with 5 mispredicted branches -> both counters read 3. Assert rst mid-run -> all outputs 0 asynchronously, before the next clock edge.
